// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - TX kind encodings, scheduler state type and round-robin helper
package eth_pkg;

  localparam logic [1:0] TX_KIND_ARP  = 2'd0;
  localparam logic [1:0] TX_KIND_ICMP = 2'd1;
  localparam logic [1:0] TX_KIND_UDP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE,
    ST_GAP
  } tx_state_t;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - 3-way round-robin arbiter with registered search pointer
module rr_arb3 import eth_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  logic [1:0] ptr;
  logic [1:0] cand1;
  logic [1:0] cand2;

  assign cand1       = rr_next(ptr);
  assign cand2       = rr_next(cand1);
  assign grant_valid = |req;

  always_comb begin
    grant_idx = ptr;
    if (req[ptr])        grant_idx = ptr;
    else if (req[cand1]) grant_idx = cand1;
    else if (req[cand2]) grant_idx = cand2;
  end

  // Pointer only moves past a requester that was actually served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (advance && grant_valid) begin
      ptr <= rr_next(grant_idx);
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - ARP/ICMP/UDP reply TX scheduler with inter-frame gap
// Optional WAIT_DONE watchdog enabled by ETH_TX_SCHED_TIMEOUT_EN.
module eth_tx_sched import eth_pkg::*; #(
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_arp_req,
  input  logic        i_ping_req,
  input  logic        i_udp_req,
  input  logic [47:0] i_arp_mac,
  input  logic [47:0] i_ping_mac,
  input  logic [47:0] i_udp_mac,
  input  logic [31:0] i_arp_ip,
  input  logic [31:0] i_ping_ip,
  input  logic [31:0] i_udp_ip,
  output logic        o_clear_arp_req,
  output logic        o_clear_ping_req,
  output logic        o_clear_udp_req,
  output logic        o_tx_start,
  output logic [1:0]  o_tx_kind,
  output logic [47:0] o_tx_mac,
  output logic [31:0] o_tx_ip,
  input  logic        i_tx_done,
  output logic        o_busy,
  output logic        o_abort
);

  localparam logic [15:0] IFG_LOAD = 16'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  tx_state_t   state, state_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic [2:0]  clr_q, clr_nxt;
  logic        start_nxt;
  logic        busy_nxt;
  logic [1:0]  kind_nxt;
  logic [47:0] mac_nxt;
  logic [31:0] ip_nxt;
  logic        arb_adv;
  logic        frame_end;
  logic        grant_valid;
  logic [1:0]  grant_idx;

`ifdef ETH_TX_SCHED_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  logic [15:0] tmo_cnt, tmo_nxt;
  logic        abort_nxt;
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES[0];
  assign o_abort    = 1'b0;
`endif

  assign o_clear_arp_req  = clr_q[0];
  assign o_clear_ping_req = clr_q[1];
  assign o_clear_udp_req  = clr_q[2];

  rr_arb3 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         ({i_udp_req, i_ping_req, i_arp_req}),
    .advance     (arb_adv),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    start_nxt = 1'b0;
    clr_nxt   = 3'b000;
    kind_nxt  = o_tx_kind;
    mac_nxt   = o_tx_mac;
    ip_nxt    = o_tx_ip;
    arb_adv   = 1'b0;
    frame_end = 1'b0;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
    tmo_nxt   = tmo_cnt;
    abort_nxt = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          state_nxt = ST_START;
          start_nxt = 1'b1;
          arb_adv   = 1'b1;
          clr_nxt   = 3'b001 << grant_idx;
          case (grant_idx)
            2'd0: begin
              kind_nxt = TX_KIND_ARP;
              mac_nxt  = i_arp_mac;
              ip_nxt   = i_arp_ip;
            end
            2'd1: begin
              kind_nxt = TX_KIND_ICMP;
              mac_nxt  = i_ping_mac;
              ip_nxt   = i_ping_ip;
            end
            default: begin
              kind_nxt = TX_KIND_UDP;
              mac_nxt  = i_udp_mac;
              ip_nxt   = i_udp_ip;
            end
          endcase
        end
      end
      ST_START: begin
        state_nxt = ST_WAIT_DONE;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
        tmo_nxt   = 16'd0;
`endif
      end
      ST_WAIT_DONE: begin
        frame_end = i_tx_done;
`ifdef ETH_TX_SCHED_TIMEOUT_EN
        // A watchdog expiry is treated exactly like a done pulse.
        if (!i_tx_done) begin
          if (tmo_cnt == TMO_LAST) begin
            frame_end = 1'b1;
            abort_nxt = 1'b1;
          end else begin
            tmo_nxt = tmo_cnt + 16'd1;
          end
        end
`endif
        if (frame_end) begin
          if (IFG_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_GAP;
            gap_nxt   = IFG_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == 16'd0) state_nxt = ST_IDLE;
        else                  gap_nxt   = gap_cnt - 16'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gap_cnt    <= 16'd0;
      clr_q      <= 3'b000;
      o_tx_start <= 1'b0;
      o_tx_kind  <= 2'd0;
      o_tx_mac   <= 48'd0;
      o_tx_ip    <= 32'd0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      gap_cnt    <= gap_nxt;
      clr_q      <= clr_nxt;
      o_tx_start <= start_nxt;
      o_tx_kind  <= kind_nxt;
      o_tx_mac   <= mac_nxt;
      o_tx_ip    <= ip_nxt;
      o_busy     <= busy_nxt;
    end
  end

`ifdef ETH_TX_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 16'd0;
      o_abort <= 1'b0;
    end else begin
      tmo_cnt <= tmo_nxt;
      o_abort <= abort_nxt;
    end
  end
`endif

endmodule
